// File: rtl/bju_pipe.sv
// Registered branch/jump resolution unit with a predictor-training update FIFO.
// Optional outcome counters are compiled in when BJU_PMU_EN is defined.
module bju_pipe #(
  parameter int unsigned BHTBTB_INDEX_WIDTH = 9,
  parameter int unsigned SLOTS_PER_SET      = 4,
  parameter int unsigned TARGET_WIDTH       = 32,
  parameter int unsigned UPD_FIFO_DEPTH     = 4
) (
  input  logic                                      clock,
  input  logic                                      reset_n,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [63:0]                               src1,
  input  logic [63:0]                               src2,
  input  logic [63:0]                               imm,
  input  logic [47:0]                               pc,
  input  logic [5:0]                                cx_type,
  input  logic                                      is_unsigned,
  input  logic                                      predict_taken,
  input  logic [TARGET_WIDTH-1:0]                   predict_target,
  input  logic                                      flush,
  output logic                                      out_valid,
  output logic [63:0]                               dest,
  output logic                                      redirect_valid,
  output logic [47:0]                               redirect_target,
  output logic                                      bht_upd_valid,
  input  logic                                      bht_upd_ready,
  output logic [BHTBTB_INDEX_WIDTH-1:0]             bht_upd_index,
  output logic [$clog2(SLOTS_PER_SET)-1:0]          bht_upd_slot,
  output logic                                      bht_upd_inc,
  output logic                                      btb_upd_valid,
  input  logic                                      btb_upd_ready,
  output logic [BHTBTB_INDEX_WIDTH-1:0]             btb_upd_index,
  output logic [SLOTS_PER_SET*TARGET_WIDTH:0]       btb_upd_wmask,
  output logic [SLOTS_PER_SET*TARGET_WIDTH:0]       btb_upd_din
`ifdef BJU_PMU_EN
  ,
  output logic [31:0]                               pmu_cnt_s1,
  output logic [31:0]                               pmu_cnt_s2,
  output logic [31:0]                               pmu_cnt_s3,
  output logic [31:0]                               pmu_cnt_s4,
  output logic [31:0]                               pmu_cnt_s5
`endif
);

  localparam int unsigned SLOT_BITS = $clog2(SLOTS_PER_SET);
  localparam int unsigned SET_W     = SLOTS_PER_SET*TARGET_WIDTH+1;
  localparam int unsigned PTR_W     = $clog2(UPD_FIFO_DEPTH);
  localparam int unsigned CNT_W     = $clog2(UPD_FIFO_DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(UPD_FIFO_DEPTH);

  typedef struct packed {
    logic [BHTBTB_INDEX_WIDTH-1:0] index;
    logic [SLOT_BITS-1:0]          slot;
    logic                          inc;
    logic                          btb_wr;
    logic [TARGET_WIDTH-1:0]       target;
  } upd_t;

  upd_t             fifo_q [UPD_FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count_q;
  logic             bht_done, btb_done;

  logic        cond_eq, cond_lt, taken, tgt_match;
  logic        s1, s2, s3, s4, s5;
  logic [47:0] jalr_sum, br_target, pc_plus4;
  logic        accept, push, pop, nonempty;
  logic        bht_fire, btb_fire, bht_complete, btb_complete;
  upd_t        head, new_entry;
  logic        unused_imm;

  assign unused_imm = ^imm[63:48];

  always_comb begin
    cond_eq   = (src1 == src2);
    cond_lt   = is_unsigned ? (src1 < src2) : ($signed(src1) < $signed(src2));
    taken     = cx_type[0] | cx_type[1] | (cx_type[2] & cond_eq) | (cx_type[3] & ~cond_eq)
              | (cx_type[4] & cond_lt) | (cx_type[5] & ~cond_lt);
    jalr_sum  = src1[47:0] + imm[47:0];
    br_target = cx_type[1] ? {jalr_sum[47:1], 1'b0} : (pc + imm[47:0]);
    pc_plus4  = pc + 48'd4;
    tgt_match = (br_target[TARGET_WIDTH-1:0] == predict_target);
    s1 = taken & predict_taken & tgt_match;
    s2 = taken & predict_taken & ~tgt_match;
    s3 = taken & ~predict_taken;
    s4 = ~taken & predict_taken;
    s5 = ~taken & ~predict_taken;
  end

  assign in_ready = (count_q != FULL_CNT);
  assign accept   = in_valid & in_ready & ~flush;
  assign push     = accept;
  assign nonempty = (count_q != '0);

  always_comb begin
    new_entry        = '0;
    new_entry.index  = pc[BHTBTB_INDEX_WIDTH+SLOT_BITS+1:SLOT_BITS+2];
    new_entry.slot   = pc[SLOT_BITS+1:2];
    new_entry.inc    = taken;
    new_entry.btb_wr = s2 | s3;
    new_entry.target = br_target[TARGET_WIDTH-1:0];
  end

  // Head retires only once both of its parts have handshaken, in any order.
  assign head          = fifo_q[rd_ptr];
  assign bht_upd_valid = nonempty & ~bht_done;
  assign btb_upd_valid = nonempty & head.btb_wr & ~btb_done;
  assign bht_fire      = bht_upd_valid & bht_upd_ready;
  assign btb_fire      = btb_upd_valid & btb_upd_ready;
  assign bht_complete  = bht_done | bht_fire;
  assign btb_complete  = ~head.btb_wr | btb_done | btb_fire;
  assign pop           = nonempty & bht_complete & btb_complete;

  assign bht_upd_index = head.index;
  assign bht_upd_slot  = head.slot;
  assign bht_upd_inc   = head.inc;
  assign btb_upd_index = head.index;

  always_comb begin
    btb_upd_wmask = '0;
    btb_upd_din   = '0;
    if (head.btb_wr) begin
      btb_upd_wmask[SET_W-1] = 1'b1;
      btb_upd_din[SET_W-1]   = 1'b1;
      btb_upd_wmask[head.slot*TARGET_WIDTH +: TARGET_WIDTH] = '1;
      btb_upd_din[head.slot*TARGET_WIDTH +: TARGET_WIDTH]   = head.target;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < UPD_FIFO_DEPTH; i++) fifo_q[i] <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count_q  <= '0;
      bht_done <= 1'b0;
      btb_done <= 1'b0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr] <= new_entry;
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + PTR_W'(1);
        bht_done <= 1'b0;
        btb_done <= 1'b0;
      end else begin
        if (bht_fire) bht_done <= 1'b1;
        if (btb_fire) btb_done <= 1'b1;
      end
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid       <= 1'b0;
      dest            <= '0;
      redirect_valid  <= 1'b0;
      redirect_target <= '0;
    end else begin
      out_valid      <= accept;
      redirect_valid <= accept & (s2 | s3 | s4);
      if (accept) begin
        dest            <= {16'b0, pc_plus4};
        redirect_target <= s4 ? pc_plus4 : br_target;
      end
    end
  end

`ifdef BJU_PMU_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pmu_cnt_s1 <= '0;
      pmu_cnt_s2 <= '0;
      pmu_cnt_s3 <= '0;
      pmu_cnt_s4 <= '0;
      pmu_cnt_s5 <= '0;
    end else if (accept) begin
      if (s1) pmu_cnt_s1 <= pmu_cnt_s1 + 32'd1;
      if (s2) pmu_cnt_s2 <= pmu_cnt_s2 + 32'd1;
      if (s3) pmu_cnt_s3 <= pmu_cnt_s3 + 32'd1;
      if (s4) pmu_cnt_s4 <= pmu_cnt_s4 + 32'd1;
      if (s5) pmu_cnt_s5 <= pmu_cnt_s5 + 32'd1;
    end
  end
`endif

endmodule
